// File: rtl/hazard_controller.sv
// Hazard controller for the 5-stage core: a 3-slot destination scoreboard (EX/MEM/WB)
// drives stall/flush/bubble enables, EX forwarding selects, ID bypass and event counters.
module hazard_controller #(
  parameter int REG_BITS = 3,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_src1,
  input  logic [REG_BITS-1:0] id_src2,
  input  logic                id_uses_src1,
  input  logic                id_uses_src2,
  input  logic [REG_BITS-1:0] id_dst,
  input  logic                id_wb,
  input  logic                id_mem_read,
  input  logic                ex_jump_taken,
  input  logic                hold_in,
  output logic                pc_en,
  output logic                if_id_en,
  output logic                if_id_flush,
  output logic                id_ex_bubble,
  output logic                pipe_en,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b,
  output logic                id_bypass1,
  output logic                id_bypass2,
  output logic [CNT_BITS-1:0] stall_count,
  output logic [CNT_BITS-1:0] flush_count
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};
  localparam logic [REG_BITS-1:0] REG_ZERO = {REG_BITS{1'b0}};

  // The WB slot's mem_read flag is never consulted, so it is not stored.
  logic [REG_BITS-1:0] ex_dst_q, ex_dst_d, ex_src1_q, ex_src1_d, ex_src2_q, ex_src2_d;
  logic                ex_wb_q, ex_wb_d, ex_mr_q, ex_mr_d, ex_us1_q, ex_us1_d, ex_us2_q, ex_us2_d;
  logic [REG_BITS-1:0] mem_dst_q, mem_dst_d, wb_dst_q, wb_dst_d;
  logic                mem_wb_q, mem_wb_d, mem_mr_q, mem_mr_d, wb_wb_q, wb_wb_d;
  logic [CNT_BITS-1:0] stall_q, stall_d, flush_q, flush_d;
  logic                load_use_s;

  function automatic logic src_match(input logic wb, input logic [REG_BITS-1:0] dst,
                                     input logic [REG_BITS-1:0] src, input logic uses);
    return wb && uses && (dst == src);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REG_BITS-1:0] src, input logic uses,
                                         input logic [REG_BITS-1:0] m_dst, input logic m_wb,
                                         input logic m_mr, input logic [REG_BITS-1:0] w_dst,
                                         input logic w_wb);
    if (src_match(m_wb, m_dst, src, uses) && !m_mr) begin
      return 2'b01;
    end else if (src_match(w_wb, w_dst, src, uses)) begin
      return 2'b10;
    end else begin
      return 2'b00;
    end
  endfunction

  always_comb begin
    load_use_s = id_valid && ex_mr_q &&
                 (src_match(ex_wb_q, ex_dst_q, id_src1, id_uses_src1) ||
                  src_match(ex_wb_q, ex_dst_q, id_src2, id_uses_src2));

    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    pipe_en      = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    // Hold beats flush beats stall; a held jump resurfaces once hold drops.
    if (hold_in) begin
      pc_en    = 1'b0;
      if_id_en = 1'b0;
      pipe_en  = 1'b0;
    end else if (ex_jump_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (load_use_s) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_bubble = 1'b1;
    end else begin
      pc_en = 1'b1;
    end

    fwd_a = fwd_sel(ex_src1_q, ex_us1_q, mem_dst_q, mem_wb_q, mem_mr_q, wb_dst_q, wb_wb_q);
    fwd_b = fwd_sel(ex_src2_q, ex_us2_q, mem_dst_q, mem_wb_q, mem_mr_q, wb_dst_q, wb_wb_q);
    id_bypass1 = src_match(wb_wb_q, wb_dst_q, id_src1, id_uses_src1);
    id_bypass2 = src_match(wb_wb_q, wb_dst_q, id_src2, id_uses_src2);
    stall_count = stall_q;
    flush_count = flush_q;
  end

  always_comb begin
    ex_dst_d = ex_dst_q;  ex_src1_d = ex_src1_q; ex_src2_d = ex_src2_q;
    ex_wb_d  = ex_wb_q;   ex_mr_d   = ex_mr_q;   ex_us1_d  = ex_us1_q;  ex_us2_d = ex_us2_q;
    mem_dst_d = mem_dst_q; mem_wb_d = mem_wb_q;  mem_mr_d  = mem_mr_q;
    wb_dst_d  = wb_dst_q;  wb_wb_d  = wb_wb_q;
    stall_d = stall_q;
    flush_d = flush_q;
    if (!hold_in) begin
      wb_dst_d  = mem_dst_q; wb_wb_d  = mem_wb_q;
      mem_dst_d = ex_dst_q;  mem_wb_d = ex_wb_q;  mem_mr_d = ex_mr_q;
      if (id_valid && !ex_jump_taken && !load_use_s) begin
        ex_dst_d = id_dst;  ex_src1_d = id_src1; ex_src2_d = id_src2;
        ex_wb_d  = id_wb;   ex_mr_d   = id_mem_read;
        ex_us1_d = id_uses_src1; ex_us2_d = id_uses_src2;
      end else begin
        ex_dst_d = REG_ZERO; ex_src1_d = REG_ZERO; ex_src2_d = REG_ZERO;
        ex_wb_d  = 1'b0; ex_mr_d = 1'b0; ex_us1_d = 1'b0; ex_us2_d = 1'b0;
      end
      if (ex_jump_taken) begin
        flush_d = (flush_q != CNT_MAX) ? flush_q + CNT_ONE : flush_q;
      end else if (load_use_s) begin
        stall_d = (stall_q != CNT_MAX) ? stall_q + CNT_ONE : stall_q;
      end else begin
        stall_d = stall_q;
      end
    end else begin
      stall_d = stall_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_dst_q <= REG_ZERO; ex_src1_q <= REG_ZERO; ex_src2_q <= REG_ZERO;
      ex_wb_q  <= 1'b0; ex_mr_q <= 1'b0; ex_us1_q <= 1'b0; ex_us2_q <= 1'b0;
      mem_dst_q <= REG_ZERO; mem_wb_q <= 1'b0; mem_mr_q <= 1'b0;
      wb_dst_q  <= REG_ZERO; wb_wb_q  <= 1'b0;
      stall_q <= {CNT_BITS{1'b0}};
      flush_q <= {CNT_BITS{1'b0}};
    end else begin
      ex_dst_q <= ex_dst_d; ex_src1_q <= ex_src1_d; ex_src2_q <= ex_src2_d;
      ex_wb_q  <= ex_wb_d;  ex_mr_q   <= ex_mr_d;   ex_us1_q  <= ex_us1_d;  ex_us2_q <= ex_us2_d;
      mem_dst_q <= mem_dst_d; mem_wb_q <= mem_wb_d; mem_mr_q <= mem_mr_d;
      wb_dst_q  <= wb_dst_d;  wb_wb_q  <= wb_wb_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed test-plan scenarios plus random traffic, checked
// against an instruction-level pipeline model; a 3-bit-counter instance checks saturation.
module tb_hazard_controller;
  logic clk = 1'b0;
  logic reset, id_valid, id_uses_src1, id_uses_src2, id_wb, id_mem_read, ex_jump_taken, hold_in;
  logic [2:0] id_src1, id_src2, id_dst;
  logic pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_en, id_bypass1, id_bypass2;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_count, flush_count;
  logic s_pc, s_ifid, s_fl, s_bub, s_pipe, s_byp1, s_byp2;
  logic [1:0] s_fwa, s_fwb;
  logic [2:0] s_stall, s_flush;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_controller #(.REG_BITS(3), .CNT_BITS(16)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_uses_src1(id_uses_src1), .id_uses_src2(id_uses_src2), .id_dst(id_dst), .id_wb(id_wb),
    .id_mem_read(id_mem_read), .ex_jump_taken(ex_jump_taken), .hold_in(hold_in),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .pipe_en(pipe_en), .fwd_a(fwd_a), .fwd_b(fwd_b), .id_bypass1(id_bypass1),
    .id_bypass2(id_bypass2), .stall_count(stall_count), .flush_count(flush_count));

  hazard_controller #(.REG_BITS(3), .CNT_BITS(3)) dut_small (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_uses_src1(id_uses_src1), .id_uses_src2(id_uses_src2), .id_dst(id_dst), .id_wb(id_wb),
    .id_mem_read(id_mem_read), .ex_jump_taken(ex_jump_taken), .hold_in(hold_in),
    .pc_en(s_pc), .if_id_en(s_ifid), .if_id_flush(s_fl), .id_ex_bubble(s_bub),
    .pipe_en(s_pipe), .fwd_a(s_fwa), .fwd_b(s_fwb), .id_bypass1(s_byp1),
    .id_bypass2(s_byp2), .stall_count(s_stall), .flush_count(s_flush));

  // Model: an in-flight instruction record per stage; index 0=EX, 1=MEM, 2=WB.
  typedef struct packed {
    bit wr; bit ld; bit [2:0] dst; bit [2:0] s1; bit [2:0] s2; bit u1; bit u2;
  } instr_t;
  instr_t stage_m [3];
  instr_t nstage_m [3];
  int m_stall, m_flush, m_sstall, m_sflush;
  int n_stall, n_flush, n_sstall, n_sflush;

  function automatic bit writes(instr_t p, bit [2:0] r);
    return p.wr && (p.dst == r);
  endfunction

  function automatic bit [1:0] fwd_of(bit [2:0] s, bit u);
    if (!u) return 2'b00;
    if (writes(stage_m[1], s) && !stage_m[1].ld) return 2'b01;
    if (writes(stage_m[2], s)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int sat_inc(int v, int maxv);
    return (v < maxv) ? v + 1 : v;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Evaluate the model for the current inputs, compare every output, prepare next state.
  task automatic settle();
    bit lu;
    bit e_pc, e_ifid, e_pipe, e_fl, e_bub;
    instr_t id_i;
    #2;
    lu = id_valid && stage_m[0].ld &&
         ((id_uses_src1 && writes(stage_m[0], id_src1)) ||
          (id_uses_src2 && writes(stage_m[0], id_src2)));
    if (hold_in) begin
      e_pc = 0; e_ifid = 0; e_pipe = 0; e_fl = 0; e_bub = 0;
    end else if (ex_jump_taken) begin
      e_pc = 1; e_ifid = 1; e_pipe = 1; e_fl = 1; e_bub = 1;
    end else if (lu) begin
      e_pc = 0; e_ifid = 0; e_pipe = 1; e_fl = 0; e_bub = 1;
    end else begin
      e_pc = 1; e_ifid = 1; e_pipe = 1; e_fl = 0; e_bub = 0;
    end
    chk("pc_en", pc_en, e_pc);
    chk("if_id_en", if_id_en, e_ifid);
    chk("pipe_en", pipe_en, e_pipe);
    chk("if_id_flush", if_id_flush, e_fl);
    chk("id_ex_bubble", id_ex_bubble, e_bub);
    chk("fwd_a", fwd_a, fwd_of(stage_m[0].s1, stage_m[0].u1));
    chk("fwd_b", fwd_b, fwd_of(stage_m[0].s2, stage_m[0].u2));
    chk("id_bypass1", id_bypass1, id_uses_src1 && writes(stage_m[2], id_src1));
    chk("id_bypass2", id_bypass2, id_uses_src2 && writes(stage_m[2], id_src2));
    chk("stall_count", stall_count, m_stall);
    chk("flush_count", flush_count, m_flush);
    chk("small_stall", s_stall, m_sstall);
    chk("small_flush", s_flush, m_sflush);

    nstage_m = stage_m;
    n_stall = m_stall; n_flush = m_flush; n_sstall = m_sstall; n_sflush = m_sflush;
    if (reset) begin
      nstage_m[0] = '0; nstage_m[1] = '0; nstage_m[2] = '0;
      n_stall = 0; n_flush = 0; n_sstall = 0; n_sflush = 0;
    end else if (!hold_in) begin
      id_i = '{wr: id_wb, ld: id_mem_read, dst: id_dst, s1: id_src1, s2: id_src2,
               u1: id_uses_src1, u2: id_uses_src2};
      nstage_m[2] = stage_m[1];
      nstage_m[1] = stage_m[0];
      nstage_m[0] = (id_valid && !ex_jump_taken && !lu) ? id_i : instr_t'(0);
      if (ex_jump_taken) begin
        n_flush = sat_inc(m_flush, 65535); n_sflush = sat_inc(m_sflush, 7);
      end else if (lu) begin
        n_stall = sat_inc(m_stall, 65535); n_sstall = sat_inc(m_sstall, 7);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    stage_m = nstage_m;
    m_stall = n_stall; m_flush = n_flush; m_sstall = n_sstall; m_sflush = n_sflush;
    #1;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic set_id(bit v, bit [2:0] s1, bit u1, bit [2:0] s2, bit u2,
                        bit [2:0] d, bit wb, bit mr);
    id_valid = v; id_src1 = s1; id_uses_src1 = u1; id_src2 = s2; id_uses_src2 = u2;
    id_dst = d; id_wb = wb; id_mem_read = mr;
    ex_jump_taken = 0; hold_in = 0; reset = 0;
  endtask

  task automatic idle(int n);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) step();
  endtask

  initial begin
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1;
    @(posedge clk); #1;
    stage_m[0] = '0; stage_m[1] = '0; stage_m[2] = '0;
    m_stall = 0; m_flush = 0; m_sstall = 0; m_sflush = 0;
    reset = 0;
    idle(2);

    // Load-use: LDD R1; ADD R2,R1,R3
    set_id(1, 0, 0, 0, 0, 1, 1, 1); step();
    set_id(1, 1, 1, 3, 1, 2, 1, 0); settle();
    chk("lu_pc_en", pc_en, 0); chk("lu_bubble", id_ex_bubble, 1); tick();
    settle(); chk("lu_release_pc", pc_en, 1); tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0); settle();
    chk("lu_fwd_a", fwd_a, 2'b10); chk("lu_stall_count", stall_count, 1); tick();

    // Back-to-back ALU: ADD R1; SUB R4,R1,R1
    idle(3);
    set_id(1, 0, 0, 0, 0, 1, 1, 0); step();
    set_id(1, 1, 1, 1, 1, 4, 1, 0); step();
    set_id(0, 0, 0, 0, 0, 0, 0, 0); settle();
    chk("alu_fwd_a", fwd_a, 2'b01); chk("alu_fwd_b", fwd_b, 2'b01); tick();
    // Distance 2
    idle(3);
    set_id(1, 0, 0, 0, 0, 1, 1, 0); step();
    idle(1);
    set_id(1, 1, 1, 1, 1, 4, 1, 0); step();
    set_id(0, 0, 0, 0, 0, 0, 0, 0); settle(); chk("d2_fwd_a", fwd_a, 2'b10); tick();
    // Both producers in flight: younger wins
    idle(3);
    set_id(1, 0, 0, 0, 0, 1, 1, 0); step();
    set_id(1, 0, 0, 0, 0, 1, 1, 0); step();
    set_id(1, 1, 1, 1, 1, 4, 1, 0); step();
    set_id(0, 0, 0, 0, 0, 0, 0, 0); settle(); chk("both_fwd_b", fwd_b, 2'b01); tick();

    // Distance 3 bypass
    idle(3);
    set_id(1, 0, 0, 0, 0, 5, 1, 0); step();
    idle(2);
    set_id(1, 5, 1, 0, 0, 6, 1, 0); settle(); chk("d3_bypass1", id_bypass1, 1);
    id_uses_src1 = 0; settle(); chk("d3_nouse_bypass1", id_bypass1, 0); tick();

    // Jump with simultaneous load-use
    idle(3);
    set_id(1, 0, 0, 0, 0, 1, 1, 1); step();
    set_id(1, 1, 1, 3, 1, 2, 1, 0); ex_jump_taken = 1; settle();
    chk("jmp_flush", if_id_flush, 1); chk("jmp_bubble", id_ex_bubble, 1); chk("jmp_pc", pc_en, 1);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0); settle();
    chk("jmp_flush_count", flush_count, 1); chk("jmp_stall_count", stall_count, 1); tick();

    // Hold for 3 cycles during a load-use
    idle(3);
    set_id(1, 0, 0, 0, 0, 1, 1, 1); step();
    set_id(1, 1, 1, 3, 1, 2, 1, 0);
    for (int i = 0; i < 3; i++) begin
      hold_in = 1; settle();
      chk("hold_pipe_en", pipe_en, 0); chk("hold_bubble", id_ex_bubble, 0); tick();
    end
    hold_in = 0; settle(); chk("post_hold_pc", pc_en, 0); tick();
    settle(); chk("post_hold_nostall", pc_en, 1); chk("post_hold_stalls", stall_count, 2); tick();

    // Reset mid-stall
    idle(3);
    set_id(1, 0, 0, 0, 0, 1, 1, 1); step();
    set_id(1, 1, 1, 3, 1, 2, 1, 0); reset = 1; step();
    reset = 0; settle();
    chk("rst_pc_en", pc_en, 1); chk("rst_stall", stall_count, 0); chk("rst_flush", flush_count, 0);
    tick();

    // Saturation on the 3-bit-counter instance
    set_id(1, 1, 1, 0, 0, 1, 1, 1);
    repeat (20) step();
    settle(); chk("sat_small_stall", s_stall, 7); tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0); ex_jump_taken = 1;
    repeat (10) step();
    settle(); chk("sat_small_flush", s_flush, 7); tick();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      set_id($urandom_range(1), $urandom_range(3), $urandom_range(1), $urandom_range(3),
             $urandom_range(1), $urandom_range(3), $urandom_range(1), $urandom_range(1));
      ex_jump_taken = ($urandom_range(5) == 0);
      hold_in = ($urandom_range(7) == 0);
      reset = ($urandom_range(63) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard controller for the 5-stage core (IF, ID, EX, MEM, WB). It tracks the destination register of every in-flight instruction in a 3-slot scoreboard mirroring the EX, MEM and WB stages. From that it generates:
- stall and flush enables for the pipeline registers;
- EX-stage operand forwarding selects;
- decode-stage register-file bypass selects;
- saturating stall and flush event counters.

## Interface
Parameters:
- REG_BITS, 3, register address width (8 architectural registers, all writable)
- CNT_BITS, 16, width of performance counters

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID stage holds a real instruction
- id_src1, id_src2  in  REG_BITS  ID source register addresses
- id_uses_src1, id_uses_src2  in  1  source actually read by the ID instruction
- id_dst  in  REG_BITS  ID destination register
- id_wb  in  1  ID instruction writes the register file
- id_mem_read  in  1  ID instruction is a load or pop
- ex_jump_taken  in  1  taken jump/branch resolved in EX this cycle
- hold_in  in  1  external freeze (e.g. memory busy)
- pc_en  out  1  PC update enable
- if_id_en  out  1  IF/ID register load enable
- if_id_flush  out  1  clear IF/ID to bubble
- id_ex_bubble  out  1  load bubble (all control zero) into ID/EX
- pipe_en  out  1  enable for ID/EX, EX/MEM, MEM/WB registers
- fwd_a, fwd_b  out  2  EX operand select: 00 ID/EX value, 01 EX/MEM result, 10 MEM/WB write_data
- id_bypass1, id_bypass2  out  1  ID read port takes WB write_data instead of register file
- stall_count, flush_count  out  CNT_BITS  saturating event counters

## Operation
- Scoreboard slots EX, MEM, WB each hold {dst, wb, mem_read}. The EX slot also holds {src1, src2, uses_src1, uses_src2}.
- Advance (pipe_en=1): WB<=MEM, MEM<=EX, and EX<=ID fields if id_valid and no stall/flush; otherwise EX<=bubble (wb=0, mem_read=0, uses=0).
- Match is defined as slot.wb=1 && slot.dst==src && uses_src=1.
- Load-use stall: id_valid && EX.mem_read && EX.wb && EX.dst matches an ID source. Response:
  - pc_en=0, if_id_en=0, id_ex_bubble=1, pipe_en=1;
  - stall_count += 1 (saturates at all-ones).
- Flush: ex_jump_taken=1. Response:
  - if_id_flush=1, id_ex_bubble=1, pc_en=1, if_id_en=1;
  - flush_count += 1 (saturating).
  - Flush overrides stall in the same cycle; stall_count is not incremented.
- Hold: hold_in=1 forces the following, and no slot or counter changes:
  - pc_en=0, if_id_en=0, pipe_en=0;
  - if_id_flush=0, id_ex_bubble=0.
  - Hold overrides flush and stall; a pending ex_jump_taken takes effect on the first cycle hold_in=0.
- Forwarding (per EX operand): MEM slot match with MEM.mem_read=0 -> 01; else WB slot match -> 10; else 00. The MEM slot has priority as the younger producer.
- A load in MEM never forwards via 01. Load-use stalling guarantees it reaches WB first.
- ID bypass: id_src matches WB slot (wb=1) -> id_bypassN=1. This covers distance-3 dependencies.
- Default (no event): pc_en=if_id_en=pipe_en=1, flush=bubble=0.

## Timing
- All control outputs are combinational from registered slots plus current ID/EX inputs, valid in the same cycle.
- Slots and counters update on posedge clk only.
- Load-use costs exactly 1 stall cycle. The next cycle the load is in MEM, no stall is raised, and the dependent instruction reaches EX with fwd=10.
- A flush removes exactly the IF and ID instructions (2-cycle penalty).
- Reset (any cycle, including mid-stall or mid-hold), next cycle:
  - all slots bubble, counters 0;
  - outputs: pc_en=1, if_id_en=1, pipe_en=1, if_id_flush=0, id_ex_bubble=0, fwd_a=fwd_b=00, id_bypass1=id_bypass2=0.
- Counters hold at 2^CNT_BITS-1; they never wrap.

## Test plan
- Load-use: LDD R1 then ADD R2,R1,R3 -> one cycle with pc_en=0, id_ex_bubble=1; next cycle ADD in EX with fwd_a=10; stall_count=1.
- Back-to-back ALU: ADD R1 then SUB R4,R1,R1 -> no stall, fwd_a=fwd_b=01; R1 produced two ahead -> 10; both in flight -> 01 wins.
- Distance 3: writer of R5 in WB while reader of R5 in ID -> id_bypass1=1; id_uses_src1=0 -> id_bypass1=0.
- Jump + load-use in same cycle: ex_jump_taken=1 with stall condition -> if_id_flush=1, id_ex_bubble=1, pc_en=1; flush_count=1, stall_count unchanged.
- Hold for 3 cycles during a load-use: outputs frozen and slots unchanged. After release, exactly one stall cycle occurs; counters increment once.
- Reset asserted mid-stall -> next cycle all outputs at reset values and counters 0; preload stall_count to max and stall -> stays at 0xFFFF.
